// File: rtl/ttc_msg_encoder.sv
// TTC-side trigger emulator: drives the L1-accept line and serialises queued
// L1/L2a/L2r messages onto the 12-bit broadcast bus, plus bcntres/evcntres.
module ttc_msg_encoder #(
  parameter int ORBIT_LEN  = 3564,
  parameter int FIFO_DEPTH = 4,
  parameter int STR_GAP    = 1,
  parameter int MSG_GAP    = 2
) (
  input  logic        gclk_40m,
  input  logic        reset,
  input  logic        orbit_en,
  input  logic        l0_req,
  input  logic        l1_req,
  input  logic [47:0] l1_data,
  input  logic        l2a_req,
  input  logic [95:0] l2a_data,
  input  logic        l2r_req,
  input  logic [11:0] l2r_data,
  input  logic        ecr_req,
  output logic        ttc_l1accept_p,
  output logic        ttc_l1accept_n,
  output logic [7:0]  ttc_saddr,
  output logic [7:0]  ttc_dout,
  output logic        ttc_doutstr,
  output logic        bcntres,
  output logic        evcntres,
  output logic [11:0] bunch_cnt,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        acc_err,
  output logic [15:0] drop_cnt
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int GMAX = (STR_GAP > MSG_GAP) ? STR_GAP : MSG_GAP;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX + 1) : 1;

  localparam logic [1:0] T_L1  = 2'd1;
  localparam logic [1:0] T_L2A = 2'd2;
  localparam logic [1:0] T_L2R = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_GAP, S_MSGGAP} state_t;

  function automatic logic [3:0] hdr_code(input logic [1:0] t);
    case (t)
      T_L1:    hdr_code = 4'd1;
      T_L2A:   hdr_code = 4'd3;
      T_L2R:   hdr_code = 4'd5;
      default: hdr_code = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] data_code(input logic [1:0] t);
    case (t)
      T_L1:    data_code = 4'd2;
      T_L2A:   data_code = 4'd4;
      T_L2R:   data_code = 4'd5;
      default: data_code = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] n_words(input logic [1:0] t);
    case (t)
      T_L1:    n_words = 4'd4;
      T_L2A:   n_words = 4'd8;
      T_L2R:   n_words = 4'd1;
      default: n_words = 4'd1;
    endcase
  endfunction

  logic [1:0]    type_mem [FIFO_DEPTH];
  logic [95:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          fifo_full_q;

  logic [1:0]    req_n_s, drop_s, wr_type_s, rd_type_s;
  logic [95:0]   wr_data_s, rd_data_s;
  logic [16:0]   drop_sum_s;
  logic          push_s, pop_s, full_s;

  state_t        state_q;
  logic [7:0]    saddr_q, dout_q;
  logic          str_q, busy_q;
  logic [95:0]   shift_q;
  logic [1:0]    typ_q;
  logic [3:0]    words_q;
  logic [GW-1:0] gap_q;

  logic          acc_p_q, acc_n_q, acc_err_q, evcntres_q, bcntres_q;
  logic [11:0]   bunch_q;

  assign rd_type_s = type_mem[rd_ptr_q];
  assign rd_data_s = data_mem[rd_ptr_q];

  // Request arbitration (L1 > L2a > L2r), FIFO occupancy and drop accounting.
  always_comb begin
    req_n_s = {1'b0, l1_req} + {1'b0, l2a_req} + {1'b0, l2r_req};
    if (l1_req) begin
      wr_type_s = T_L1;
      wr_data_s = {l1_data, 48'h0};
    end else if (l2a_req) begin
      wr_type_s = T_L2A;
      wr_data_s = l2a_data;
    end else if (l2r_req) begin
      wr_type_s = T_L2R;
      wr_data_s = {l2r_data, 84'h0};
    end else begin
      wr_type_s = 2'd0;
      wr_data_s = 96'h0;
    end
    pop_s      = (state_q == S_LOAD);
    full_s     = (count_q == CW'(FIFO_DEPTH));
    push_s     = (req_n_s != 2'd0) && (!full_s || pop_s);
    drop_s     = req_n_s - {1'b0, push_s};
    count_d    = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    drop_sum_s = {1'b0, drop_cnt_q} + {15'd0, drop_s};
    drop_cnt_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge gclk_40m) begin
    if (push_s) begin
      type_mem[wr_ptr_q] <= wr_type_s;
      data_mem[wr_ptr_q] <= wr_data_s;
    end
  end

  // FIFO pointers, occupancy, full flag and saturating drop counter.
  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      fifo_full_q <= 1'b0;
      drop_cnt_q  <= 16'h0;
    end else begin
      wr_ptr_q    <= push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_q    <= pop_s ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
      count_q     <= count_d;
      fifo_full_q <= (count_d == CW'(FIFO_DEPTH));
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Message serialiser; the first word is launched on the LOAD->STROBE edge.
  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      state_q <= S_IDLE;
      saddr_q <= 8'h0;
      dout_q  <= 8'h0;
      str_q   <= 1'b0;
      busy_q  <= 1'b0;
      shift_q <= 96'h0;
      typ_q   <= 2'd0;
      words_q <= 4'd0;
      gap_q   <= {GW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          str_q <= 1'b0;
          if (count_q != {CW{1'b0}}) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= (count_d != {CW{1'b0}});
          end
        end
        S_LOAD: begin
          state_q <= S_STROBE;
          str_q   <= 1'b1;
          busy_q  <= 1'b1;
          typ_q   <= rd_type_s;
          saddr_q <= {hdr_code(rd_type_s), rd_data_s[95:92]};
          dout_q  <= rd_data_s[91:84];
          shift_q <= {rd_data_s[83:0], 12'h0};
          words_q <= n_words(rd_type_s) - 4'd1;
        end
        S_STROBE: begin
          str_q  <= 1'b0;
          busy_q <= 1'b1;
          if (words_q != 4'd0) begin
            state_q <= S_GAP;
            gap_q   <= GW'(STR_GAP - 1);
          end else begin
            state_q <= S_MSGGAP;
            gap_q   <= GW'(MSG_GAP - 1);
          end
        end
        S_GAP: begin
          busy_q <= 1'b1;
          if (gap_q == {GW{1'b0}}) begin
            state_q <= S_STROBE;
            str_q   <= 1'b1;
            saddr_q <= {data_code(typ_q), shift_q[95:92]};
            dout_q  <= shift_q[91:84];
            shift_q <= {shift_q[83:0], 12'h0};
            words_q <= words_q - 4'd1;
          end else begin
            gap_q   <= gap_q - {{(GW-1){1'b0}}, 1'b1};
          end
        end
        S_MSGGAP: begin
          if (gap_q == {GW{1'b0}}) begin
            state_q <= S_IDLE;
            busy_q  <= (count_d != {CW{1'b0}});
          end else begin
            gap_q   <= gap_q - {{(GW-1){1'b0}}, 1'b1};
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          str_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Accept line, coincidence flag, event-counter reset and orbit counter.
  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      acc_p_q    <= 1'b0;
      acc_n_q    <= 1'b1;
      acc_err_q  <= 1'b0;
      evcntres_q <= 1'b0;
      bunch_q    <= 12'd0;
      bcntres_q  <= 1'b0;
    end else begin
      acc_p_q    <= l0_req | l1_req;
      acc_n_q    <= ~(l0_req | l1_req);
      acc_err_q  <= acc_err_q | (l0_req & l1_req);
      evcntres_q <= ecr_req;
      if (!orbit_en) begin
        bcntres_q <= 1'b0;
      end else if (bunch_q == 12'(ORBIT_LEN - 1)) begin
        bunch_q   <= 12'd0;
        bcntres_q <= 1'b1;
      end else begin
        bunch_q   <= bunch_q + 12'd1;
        bcntres_q <= 1'b0;
      end
    end
  end

  assign ttc_l1accept_p = acc_p_q;
  assign ttc_l1accept_n = acc_n_q;
  assign ttc_saddr      = saddr_q;
  assign ttc_dout       = dout_q;
  assign ttc_doutstr    = str_q;
  assign bcntres        = bcntres_q;
  assign evcntres       = evcntres_q;
  assign bunch_cnt      = bunch_q;
  assign tx_busy        = busy_q;
  assign fifo_full      = fifo_full_q;
  assign acc_err        = acc_err_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ttc_msg_encoder.sv
// Scoreboard bench for ttc_msg_encoder: stimulus pushes expected broadcast
// words (with expected strobe cycle where timing is fixed); a monitor pops them.
module tb_ttc_msg_encoder;

  localparam int ORBIT_LEN = 3564;

  logic        gclk_40m = 1'b0;
  logic        reset, orbit_en, l0_req, l1_req, l2a_req, l2r_req, ecr_req;
  logic [47:0] l1_data;
  logic [95:0] l2a_data;
  logic [11:0] l2r_data;
  logic        ttc_l1accept_p, ttc_l1accept_n, ttc_doutstr, bcntres, evcntres;
  logic        tx_busy, fifo_full, acc_err;
  logic [7:0]  ttc_saddr, ttc_dout;
  logic [11:0] bunch_cnt;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [15:0] word;
    int          exp_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bc_pulses = 0;
  int          last_bc = -1;
  logic [11:0] prev_bunch = 12'd0;

  always #5 gclk_40m = ~gclk_40m;
  always @(posedge gclk_40m) cyc <= cyc + 1;

  ttc_msg_encoder dut (
    .gclk_40m(gclk_40m), .reset(reset), .orbit_en(orbit_en),
    .l0_req(l0_req), .l1_req(l1_req), .l1_data(l1_data),
    .l2a_req(l2a_req), .l2a_data(l2a_data),
    .l2r_req(l2r_req), .l2r_data(l2r_data), .ecr_req(ecr_req),
    .ttc_l1accept_p(ttc_l1accept_p), .ttc_l1accept_n(ttc_l1accept_n),
    .ttc_saddr(ttc_saddr), .ttc_dout(ttc_dout), .ttc_doutstr(ttc_doutstr),
    .bcntres(bcntres), .evcntres(evcntres), .bunch_cnt(bunch_cnt),
    .tx_busy(tx_busy), .fifo_full(fifo_full), .acc_err(acc_err),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] w, input int c);
    exp_t e;
    e.word    = w;
    e.exp_cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(negedge gclk_40m);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((tx_busy || sb_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 300), 32'd1);
  endtask

  // Monitor: pops the scoreboard on each strobe and checks orbit pulses.
  always @(negedge gclk_40m) begin
    chk("acc_n_complement", 32'(ttc_l1accept_n ^ ttc_l1accept_p), 32'd1);
    if (ttc_doutstr) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %04h expected no strobe (cycle %0d)",
                 {ttc_saddr, ttc_dout}, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe_word", {16'h0, ttc_saddr, ttc_dout}, {16'h0, mon_e.word});
        if (mon_e.exp_cyc >= 0) chk("strobe_cycle", cyc, mon_e.exp_cyc);
      end
    end
    if (bcntres) begin
      bc_pulses++;
      chk("bcntres_bunch", 32'(bunch_cnt), 32'd0);
      chk("bcntres_prev", 32'(prev_bunch), 32'(ORBIT_LEN - 1));
      if (last_bc >= 0) chk("bcntres_spacing", cyc - last_bc, ORBIT_LEN);
      last_bc = cyc;
    end
    prev_bunch = bunch_cnt;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; orbit_en = 1'b0; l0_req = 1'b0; l1_req = 1'b0;
    l2a_req = 1'b0; l2r_req = 1'b0; ecr_req = 1'b0;
    l1_data = 48'h0; l2a_data = 96'h0; l2r_data = 12'h0;
    repeat (3) step();

    chk("rst_acc_p", 32'(ttc_l1accept_p), 32'd0);
    chk("rst_acc_n", 32'(ttc_l1accept_n), 32'd1);
    chk("rst_saddr", 32'(ttc_saddr), 32'd0);
    chk("rst_dout", 32'(ttc_dout), 32'd0);
    chk("rst_doutstr", 32'(ttc_doutstr), 32'd0);
    chk("rst_bcntres", 32'(bcntres), 32'd0);
    chk("rst_evcntres", 32'(evcntres), 32'd0);
    chk("rst_bunch", 32'(bunch_cnt), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_acc_err", 32'(acc_err), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    step();

    // L1 from idle: accept at +1, strobes at +3,+5,+7,+9, busy drops at +12
    n = cyc;
    l1_req = 1'b1; l1_data = 48'h111_222_333_444;
    push_exp(16'h1111, n + 3); push_exp(16'h2222, n + 5);
    push_exp(16'h2333, n + 7); push_exp(16'h2444, n + 9);
    step();
    l1_req = 1'b0;
    chk("l1_accept_pulse", 32'(ttc_l1accept_p), 32'd1);
    chk("l1_busy_early", 32'(tx_busy), 32'd1);
    step();
    chk("l1_accept_end", 32'(ttc_l1accept_p), 32'd0);
    while (cyc < n + 11) step();
    chk("l1_busy_msggap", 32'(tx_busy), 32'd1);
    step();
    chk("l1_busy_fall", 32'(tx_busy), 32'd0);
    chk("l1_sb_drained", sb_q.size(), 32'd0);

    // L2a: eight words A01..A08
    n = cyc;
    l2a_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l2a_data[95 - 12*i -: 12] = 12'hA01 + 12'(i);
      push_exp({(i == 0) ? 4'h3 : 4'h4, 4'hA, 8'(i + 1)}, n + 3 + 2*i);
    end
    step();
    l2a_req = 1'b0;
    chk("l2a_no_accept", 32'(ttc_l1accept_p), 32'd0);
    wait_idle("l2a");

    // L0/L1 coincidence
    n = cyc;
    l0_req = 1'b1; l1_req = 1'b1; l1_data = 48'hABC_DEF_012_345;
    push_exp(16'h1ABC, n + 3); push_exp(16'h2DEF, n + 5);
    push_exp(16'h2012, n + 7); push_exp(16'h2345, n + 9);
    step();
    l0_req = 1'b0; l1_req = 1'b0;
    chk("coinc_accept", 32'(ttc_l1accept_p), 32'd1);
    chk("coinc_acc_err", 32'(acc_err), 32'd1);
    step();
    chk("coinc_single_pulse", 32'(ttc_l1accept_p), 32'd0);
    wait_idle("coinc");
    chk("acc_err_sticky", 32'(acc_err), 32'd1);

    // Simultaneous L1+L2a+L2r into empty FIFO: L1 kept, two dropped
    n = cyc;
    l1_req = 1'b1; l2a_req = 1'b1; l2r_req = 1'b1;
    l1_data = 48'h777_888_999_AAA; l2r_data = 12'h5FF;
    push_exp(16'h1777, n + 3); push_exp(16'h2888, n + 5);
    push_exp(16'h2999, n + 7); push_exp(16'h2AAA, n + 9);
    step();
    l1_req = 1'b0; l2a_req = 1'b0; l2r_req = 1'b0;
    chk("simul_drop", 32'(drop_cnt), 32'd2);
    wait_idle("simul");

    // Five L2r while busy: four queued, one dropped
    n = cyc;
    l1_req = 1'b1; l1_data = 48'h5A5_000_FFF_123;
    push_exp(16'h15A5, n + 3); push_exp(16'h2000, n + 5);
    push_exp(16'h2FFF, n + 7); push_exp(16'h2123, n + 9);
    step();
    l1_req = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      l2r_req = 1'b1;
      l2r_data = 12'h501 + 12'(i);
      if (i < 4) push_exp({8'h55, 8'(i + 1)}, -1);
      step();
    end
    l2r_req = 1'b0;
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd3);
    wait_idle("ovf");
    chk("ovf_full_clear", 32'(fifo_full), 32'd0);

    // Event counter reset
    ecr_req = 1'b1;
    step();
    ecr_req = 1'b0;
    chk("ecr_pulse", 32'(evcntres), 32'd1);
    step();
    chk("ecr_end", 32'(evcntres), 32'd0);

    // Orbit: 7133 enabled cycles -> two wraps, bunch ends at 5
    orbit_en = 1'b1;
    repeat (7133) step();
    orbit_en = 1'b0;
    chk("orbit_pulses", bc_pulses, 32'd2);
    chk("orbit_bunch_end", 32'(bunch_cnt), 32'd5);
    repeat (3) step();
    chk("orbit_bunch_hold", 32'(bunch_cnt), 32'd5);
    chk("orbit_bcntres_off", 32'(bcntres), 32'd0);

    // Reset during word 3 of an L2a message
    orbit_en = 1'b1;
    n = cyc;
    l2a_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l2a_data[95 - 12*i -: 12] = 12'hB01 + 12'(i);
      push_exp({(i == 0) ? 4'h3 : 4'h4, 4'hB, 8'(i + 1)}, n + 3 + 2*i);
    end
    step();
    l2a_req = 1'b0;
    while (cyc < n + 7) step();
    chk("abort_word3_strobe", 32'(ttc_doutstr), 32'd1);
    chk("abort_words_left", sb_q.size(), 32'd5);
    reset = 1'b1;
    step();
    chk("abort_doutstr", 32'(ttc_doutstr), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_bunch", 32'(bunch_cnt), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'd0);
    chk("abort_acc_n", 32'(ttc_l1accept_n), 32'd1);
    chk("abort_acc_err", 32'(acc_err), 32'd0);
    sb_q.delete();
    step();
    reset = 1'b0; orbit_en = 1'b0;
    repeat (20) step();
    chk("final_sb_empty", sb_q.size(), 32'd0);
    chk("final_idle", 32'(tx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
